mc_ctrl: RTL

- Multicycle control FSM: the driving end of the ALU interface.
- Decodes Op/Funct from the instruction register.
- Sequences fetch/decode/execute/memory/writeback.
- Drives ALUOp, operand selects and all architectural write strobes; consumes the ALU Zero flag for beq.
- Replaces the single-cycle decoder when the datapath moves to shared memory/ALU with ALUOut, MDR and IR registers.

---
 rtl/mc_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects, ALU operation and architectural write strobes.
module mc_ctrl #(
    parameter int W_STATE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               IorD,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [4:0]         ALUOp,
    output logic               ExtOp,
    output logic [1:0]         RegDst,
    output logic [1:0]         WDSel,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic [W_STATE-1:0] state
);

    localparam logic [4:0] ALUOP_ADD  = 5'd1;
    localparam logic [4:0] ALUOP_ADDU = 5'd2;
    localparam logic [4:0] ALUOP_SUB  = 5'd3;
    localparam logic [4:0] ALUOP_SUBU = 5'd4;
    localparam logic [4:0] ALUOP_AND  = 5'd5;
    localparam logic [4:0] ALUOP_OR   = 5'd6;
    localparam logic [4:0] ALUOP_SLT  = 5'd7;
    localparam logic [4:0] ALUOP_SLL  = 5'd8;
    localparam logic [4:0] ALUOP_SRL  = 5'd9;
    localparam logic [4:0] ALUOP_SRA  = 5'd10;

    localparam logic [W_STATE-1:0] S_FETCH  = W_STATE'(0);
    localparam logic [W_STATE-1:0] S_DECODE = W_STATE'(1);
    localparam logic [W_STATE-1:0] S_MEMADR = W_STATE'(2);
    localparam logic [W_STATE-1:0] S_MEMRD  = W_STATE'(3);
    localparam logic [W_STATE-1:0] S_MEMWB  = W_STATE'(4);
    localparam logic [W_STATE-1:0] S_MEMWR  = W_STATE'(5);
    localparam logic [W_STATE-1:0] S_EXE_R  = W_STATE'(6);
    localparam logic [W_STATE-1:0] S_ALUWB  = W_STATE'(7);
    localparam logic [W_STATE-1:0] S_EXE_I  = W_STATE'(8);
    localparam logic [W_STATE-1:0] S_IWB    = W_STATE'(9);
    localparam logic [W_STATE-1:0] S_BRANCH = W_STATE'(10);
    localparam logic [W_STATE-1:0] S_JUMP   = W_STATE'(11);
    localparam logic [W_STATE-1:0] S_JR     = W_STATE'(12);

    logic [W_STATE-1:0] state_reg;
    logic [W_STATE-1:0] state_next;
    logic               r_funct_ok;
    logic [4:0]         r_aluop;
    logic               is_addi;

    // R-type Funct -> ALU operation; also reused in ALUWB so ALUOp stays steady.
    always_comb begin
        r_funct_ok = 1'b1;
        r_aluop    = ALUOP_ADDU;
        case (Funct)
            6'b100000: r_aluop = ALUOP_ADD;
            6'b100001: r_aluop = ALUOP_ADDU;
            6'b100010: r_aluop = ALUOP_SUB;
            6'b100011: r_aluop = ALUOP_SUBU;
            6'b100100: r_aluop = ALUOP_AND;
            6'b100101: r_aluop = ALUOP_OR;
            6'b101010: r_aluop = ALUOP_SLT;
            6'b000000: r_aluop = ALUOP_SLL;
            6'b000010: r_aluop = ALUOP_SRL;
            6'b000011: r_aluop = ALUOP_SRA;
            default:   r_funct_ok = 1'b0;
        endcase
    end

    assign is_addi = (Op == 6'b001000);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    6'b100011, 6'b101011: state_next = S_MEMADR;
                    6'b000000: begin
                        if (Funct == 6'b001000) begin
                            state_next = S_JR;
                        end else if (r_funct_ok) begin
                            state_next = S_EXE_R;
                        end
                    end
                    6'b001000, 6'b001101: state_next = S_EXE_I;
                    6'b000100:            state_next = S_BRANCH;
                    6'b000010, 6'b000011: state_next = S_JUMP;
                    default:              state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (Op == 6'b100011) begin
                    state_next = S_MEMRD;
                end else if (Op == 6'b101011) begin
                    state_next = S_MEMWR;
                end
            end
            S_MEMRD:  state_next = S_MEMWB;
            S_EXE_R:  state_next = S_ALUWB;
            S_EXE_I:  state_next = S_IWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IorD       = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = ALUOP_ADDU;
        ExtOp      = 1'b0;
        RegDst     = 2'b00;
        WDSel      = 2'b00;
        PCSource   = 2'b00;
        illegal_op = 1'b0;
        case (state_reg)
            S_FETCH: begin
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ExtOp   = 1'b1;
                illegal_op = (state_next == S_FETCH);
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp   = 1'b1;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                RegWrite = 1'b1;
                WDSel    = 2'b01;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXE_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = r_aluop;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
                ALUOp    = r_aluop;
            end
            S_EXE_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp   = is_addi;
                ALUOp   = is_addi ? ALUOP_ADD : ALUOP_OR;
            end
            S_IWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALUOP_SUBU;
                PCSource = 2'b01;
                PCWrite  = Zero;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                if (Op == 6'b000011) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    WDSel    = 2'b10;
                end
            end
            S_JR: begin
                PCSource = 2'b11;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
        // Reset wins over everything so an abandoned instruction never commits.
        if (rst) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            IorD       = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            ALUOp      = 5'd0;
            ExtOp      = 1'b0;
            RegDst     = 2'b00;
            WDSel      = 2'b00;
            PCSource   = 2'b00;
            illegal_op = 1'b0;
        end
    end

    assign state = state_reg;

endmodule
